// File: rtl/instr_pkg.sv
// instr_pkg: instruction field widths, loader states and word packing shared by load and fetch paths
package instr_pkg;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;
    localparam int WORD_W   = OPCODE_W + 2 * REG_W + IMM_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_B3   = 3'd4
    } ld_state_e;

    function automatic logic [WORD_W-1:0] pack_instr(
        input logic [OPCODE_W-1:0] opcode,
        input logic [REG_W-1:0]    reg1,
        input logic [REG_W-1:0]    reg2,
        input logic [IMM_W-1:0]    imm
    );
        return {opcode, reg1, reg2, imm};
    endfunction
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: field handshake into the loader and byte write bus out to instruction memory
interface instr_mem_loader_if
    import instr_pkg::*;
#(
    parameter int DEPTHI = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] in_opcode;
    logic [REG_W-1:0]    in_reg1;
    logic [REG_W-1:0]    in_reg2;
    logic [IMM_W-1:0]    in_imm;
    logic                mem_we;
    logic [DEPTHI-1:0]   mem_addr;
    logic [7:0]          mem_wdata;

    modport master (
        output in_valid, in_opcode, in_reg1, in_reg2, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_opcode, in_reg1, in_reg2, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs decoded fields into a word and writes it big-endian, one byte per cycle
module instr_mem_loader
    import instr_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTHI = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_load,
    input  logic [DEPTHI-1:0] base_addr,
    instr_mem_loader_if.slave bus,
    output logic              busy,
    output logic              full,
    output logic [DEPTHI-2:0] word_count
);
    localparam logic [2:0] IDLE = S_IDLE;
    localparam logic [2:0] B0   = S_B0;
    localparam logic [2:0] B3   = S_B3;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [DEPTHI-1:0] ptr;
    logic [DEPTHI-1:0] last_addr;
    logic [WIDTH-1:0]  shreg;
    logic [7:0]        last_data;
    logic              accept;

    assign busy          = state != IDLE;
    assign bus.in_ready  = !busy && !full && !base_load;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.mem_we    = busy;
    assign bus.mem_addr  = busy ? ptr : last_addr;
    assign bus.mem_wdata = busy ? shreg[WIDTH-1 -: 8] : last_data;

    // Idle waits for an accept; byte states step B0..B3 and fall back to idle
    always_comb state_nxt = !busy ? (accept ? B0 : IDLE) : (state == B3 ? IDLE : state + 3'd1);

    // State register; reset aborts any word in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Shift register: load the packed word on accept, move the next byte to the top each write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        shreg <= '0;
        else if (accept) shreg <= pack_instr(bus.in_opcode, bus.in_reg1, bus.in_reg2, bus.in_imm);
        else if (busy)   shreg <= shreg << 8;
    end

    // Pointer, last written byte, word counter and sticky wrap flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            last_addr  <= '0;
            last_data  <= '0;
            full       <= 1'b0;
            word_count <= '0;
        end else if (busy) begin
            ptr       <= ptr + DEPTHI'(1);
            last_addr <= ptr;
            last_data <= shreg[WIDTH-1 -: 8];
            if (state == B3 && word_count != '1) word_count <= word_count + (DEPTHI-1)'(1);
            if (state == B3 && ptr == '1) full <= 1'b1;
        end else if (base_load) begin
            ptr        <= base_addr & ~DEPTHI'(3);
            full       <= 1'b0;
            word_count <= '0;
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: queue-based byte-write model plus directed and random stimulus for the loader
module tb_instr_mem_loader;
    import instr_pkg::*;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       base_load = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic       busy;
    logic       full;
    logic [6:0] word_count;

    instr_mem_loader_if #(.DEPTHI(8)) bus ();

    instr_mem_loader #(.WIDTH(32), .DEPTHI(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .base_load (base_load),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .full      (full),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        bit         last;
    } wr_t;

    wr_t        q[$];
    wr_t        e;
    logic [7:0] m_ptr  = 8'h00;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_d = 8'h00;
    logic       m_full = 1'b0;
    logic [6:0] m_cnt  = 7'h00;
    logic [31:0] m_word;
    logic [7:0] mem [256];

    // Model: every accepted word becomes four pending byte writes, one retired per clock
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_ptr = 0; m_full = 0; m_cnt = 0; last_a = 0; last_d = 0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            last_a = e.a;
            last_d = e.d;
            m_ptr = e.a + 8'd1;
            if (e.last) begin
                if (m_cnt != 7'h7F) m_cnt = m_cnt + 7'd1;
                if (e.a == 8'hFF) m_full = 1'b1;
            end
        end else if (base_load) begin
            m_ptr = {base_addr[7:2], 2'b00};
            m_full = 0;
            m_cnt = 0;
        end else if (bus.in_valid && !m_full) begin
            m_word = {bus.in_opcode, bus.in_reg1, bus.in_reg2, bus.in_imm};
            for (int i = 0; i < 4; i++)
                q.push_back('{a: m_ptr + 8'(i), d: 8'(m_word >> (24 - 8 * i)), last: (i == 3)});
        end
    end

    // Fetch-side memory image built from the write strobes
    always @(posedge clk) begin
        edge_n++;
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // Compare every cycle against the model
    always @(negedge clk) begin
        chk("busy", busy, q.size() > 0);
        chk("mem_we", bus.mem_we, q.size() > 0);
        if (q.size() > 0) begin
            chk("mem_addr", bus.mem_addr, q[0].a);
            chk("mem_wdata", bus.mem_wdata, q[0].d);
        end else begin
            chk("mem_addr_hold", bus.mem_addr, last_a);
            chk("mem_wdata_hold", bus.mem_wdata, last_d);
        end
        chk("full", full, m_full);
        chk("word_count", word_count, m_cnt);
        chk("in_ready", bus.in_ready, q.size() == 0 && !m_full && !base_load);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_f(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2, input logic [15:0] imm);
        bus.in_opcode = op;
        bus.in_reg1   = r1;
        bus.in_reg2   = r2;
        bus.in_imm    = imm;
    endtask

    task automatic wait_accept(output int at);
        bit acc;
        at = -1;
        for (int n = 0; n < 20; n++) begin
            #1;
            acc = bus.in_ready && bus.in_valid;
            tick();
            if (acc) begin
                at = edge_n;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic send_f(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2, input logic [15:0] imm);
        int t;
        set_f(op, r1, r2, imm);
        bus.in_valid = 1'b1;
        wait_accept(t);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] fetch(input logic [7:0] a);
        return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    endfunction

    initial begin
        int t1, t2;
        logic [31:0] w;
        bus.in_valid = 1'b0;
        set_f(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_wc", word_count, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) tick();

        base_load = 1; base_addr = 8'h10; tick(); base_load = 0;
        send_f(6'h08, 5'd1, 5'd2, 16'h0005);
        repeat (6) tick();
        chk("b10", mem[8'h10], 8'h20);
        chk("b11", mem[8'h11], 8'h22);
        chk("b12", mem[8'h12], 8'h00);
        chk("b13", mem[8'h13], 8'h05);
        chk("wc1", word_count, 1);

        set_f(6'h3F, 5'd31, 5'd0, 16'hBEEF);
        bus.in_valid = 1'b1;
        wait_accept(t1);
        set_f(6'h01, 5'd2, 5'd3, 16'h1234);
        wait_accept(t2);
        bus.in_valid = 1'b0;
        chk("throughput", t2 - t1, 5);
        repeat (6) tick();
        w = fetch(8'h14);
        chk("dec_op", w[31:26], 6'h3F);
        chk("dec_r1", w[25:21], 5'd31);
        chk("dec_r2", w[20:16], 5'd0);
        chk("dec_imm", w[15:0], 16'hBEEF);
        chk("dec_w2", fetch(8'h18), 32'h04431234);
        chk("wc3", word_count, 3);

        base_load = 1; base_addr = 8'hFC; tick(); base_load = 0;
        send_f(6'h15, 5'd7, 5'd9, 16'hA5C3);
        repeat (5) tick();
        #1;
        chk("full_set", full, 1);
        chk("full_ready", bus.in_ready, 0);
        chk("top_word", fetch(8'hFC), 32'h54E9A5C3);
        bus.in_valid = 1'b1;
        repeat (8) tick();
        chk("full_no_accept", busy, 0);
        bus.in_valid = 1'b0;
        base_load = 1; base_addr = 8'h00; tick(); base_load = 0;
        #1;
        chk("full_clear", full, 0);
        chk("ready_back", bus.in_ready, 1);

        send_f(6'h2A, 5'd4, 5'd5, 16'h7777);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_b2_we", bus.mem_we, 0);
        chk("rst_b2_busy", busy, 0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("rst_b2_wc", word_count, 0);

        base_load = 1; base_addr = 8'h13; tick(); base_load = 0;
        send_f(6'h11, 5'd3, 5'd6, 16'hC0DE);
        tick();
        base_load = 1; base_addr = 8'h40; tick(); base_load = 0;
        repeat (5) tick();
        chk("bl_ignored", fetch(8'h10), 32'h4466C0DE);
        chk("bl_ignored_wc", word_count, 1);

        base_load = 1; base_addr = 8'h20;
        set_f(6'h00, 5'd1, 5'd1, 16'h0001);
        bus.in_valid = 1'b1;
        #1;
        chk("bl_vs_valid_ready", bus.in_ready, 0);
        tick();
        chk("bl_vs_valid_busy", busy, 0);
        base_load = 0;
        wait_accept(t1);
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("after_bl_word", fetch(8'h20), 32'h00210001);

        repeat (600) begin
            rst       = ($urandom % 150) != 0;
            base_load = ($urandom % 10) == 0;
            base_addr = 8'($urandom);
            bus.in_valid = 1'($urandom);
            set_f(6'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            tick();
        end
        rst = 1'b1;
        base_load = 1'b0;
        bus.in_valid = 1'b0;
        repeat (6) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
